alarm_scheduler: RTL and testbench

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_pkg.sv | 17 +
 rtl/sec_tick.sv | 32 +++
 rtl/alarm_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_alarm_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types for the alarm scheduler: FSM state encoding and packed BCD time.
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRing,
    StSnooze
  } state_e;

  typedef struct packed {
    logic [3:0] hourdec;
    logic [3:0] hourone;
    logic [3:0] mindec;
    logic [3:0] minone;
  } bcd_time_t;

endpackage

// File: rtl/sec_tick.sv
// One-second tick generator: single-cycle pulse every TICK_DIV clocks while running.
// The divider is held at zero whenever it is not running, so every RING entry starts a
// fresh second.
module sec_tick #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_run,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign o_tick = i_run & w_wrap;

  // Divider: counts only while running, held at zero otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!i_run || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: matches stored BCD alarm times on minute changes, queues
// triggered slots as pending and rings them one at a time with snooze and auto-dismiss.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned NSLOT      = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [3:0]               hourdec_now,
  input  logic [3:0]               hourone_now,
  input  logic [3:0]               mindec_now,
  input  logic [3:0]               minone_now,
  input  logic                     cfg_we,
  input  logic [$clog2(NSLOT)-1:0] cfg_slot,
  input  logic                     cfg_en,
  input  logic [3:0]               cfg_hourdec,
  input  logic [3:0]               cfg_hourone,
  input  logic [3:0]               cfg_mindec,
  input  logic [3:0]               cfg_minone,
  input  logic                     off_bud,
  input  logic                     snooze,
  output logic                     aud_en,
  output logic [$clog2(NSLOT)-1:0] ring_slot,
  output logic [NSLOT-1:0]         pending
);

  localparam int unsigned SW   = $clog2(NSLOT);
  localparam int unsigned SECW = $clog2(RING_SEC + 1);
  localparam int unsigned MINW = $clog2(SNOOZE_MIN + 1);

  state_e          r_state;
  logic            r_aud_en;
  logic [SW-1:0]   r_ring_slot;
  logic [NSLOT-1:0] r_pending;
  logic [SECW-1:0] r_sec_cnt;
  logic [MINW-1:0] r_min_cnt;

  bcd_time_t       r_now;
  logic            r_armed;
  bcd_time_t       r_slot_time [NSLOT];
  logic [NSLOT-1:0] r_slot_en;

  bcd_time_t        w_now;
  bcd_time_t        w_cfg_time;
  logic             w_min_evt;
  logic             w_tick;
  logic [NSLOT-1:0] w_match;
  logic [NSLOT-1:0] w_cfg_clr;
  logic [NSLOT-1:0] w_ring_oh;
  logic [NSLOT-1:0] w_avail;
  logic [NSLOT-1:0] w_pending_d;
  logic [SW-1:0]    w_sel;
  logic             w_dismiss;
  logic             w_snz_done;

  assign w_now      = '{hourdec: hourdec_now, hourone: hourone_now,
                        mindec: mindec_now, minone: minone_now};
  assign w_cfg_time = '{hourdec: cfg_hourdec, hourone: cfg_hourone,
                        mindec: cfg_mindec, minone: cfg_minone};

  // The first cycle after reset compares against a stale zero time, so it is masked.
  assign w_min_evt = r_armed && (w_now != r_now);

  assign aud_en    = r_aud_en;
  assign ring_slot = r_ring_slot;
  assign pending   = r_pending;

  sec_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_sec_tick (
    .clk   (clk),
    .rstn  (rstn),
    .i_run (r_state == StRing),
    .o_tick(w_tick)
  );

  // Current-time register and minute-event arming.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_now   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_now   <= w_now;
      r_armed <= 1'b1;
    end
  end

  // Slot configuration storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot_en <= '0;
      for (int i = 0; i < int'(NSLOT); i++) r_slot_time[i] <= '0;
    end else if (cfg_we && (32'(cfg_slot) < NSLOT)) begin
      r_slot_en[cfg_slot]   <= cfg_en;
      r_slot_time[cfg_slot] <= w_cfg_time;
    end
  end

  // Match detection, dismiss/snooze conditions, pending next-state and IDLE selection.
  always_comb begin
    w_match   = '0;
    w_cfg_clr = '0;
    w_ring_oh = '0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      w_match[i]   = r_slot_en[i] && (r_slot_time[i] == w_now);
      w_cfg_clr[i] = cfg_we && !cfg_en && (cfg_slot == SW'(i));
      w_ring_oh[i] = (r_ring_slot == SW'(i));
    end

    w_dismiss = (r_state != StIdle) &&
                (off_bud || (cfg_we && !cfg_en && (cfg_slot == r_ring_slot)) ||
                 ((r_state == StRing) && w_tick && (r_sec_cnt == SECW'(RING_SEC - 1))));
    w_snz_done = (r_state == StSnooze) && w_min_evt &&
                 (r_min_cnt == MINW'(SNOOZE_MIN - 1));

    // Clears are applied after new matches so a disable or dismiss always wins.
    w_pending_d = (r_pending | (w_min_evt ? w_match : '0)) & ~w_cfg_clr &
                  ~(w_dismiss ? w_ring_oh : '0);

    // A slot being disabled this cycle must not be picked up by IDLE.
    w_avail = r_pending & ~w_cfg_clr;
    w_sel   = '0;
    for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
      if (w_avail[i]) w_sel = SW'(i);
    end
  end

  // Sounder FSM with registered aud_en, ring_slot, pending and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_aud_en    <= 1'b0;
      r_ring_slot <= '0;
      r_pending   <= '0;
      r_sec_cnt   <= '0;
      r_min_cnt   <= '0;
    end else begin
      r_pending <= w_pending_d;
      unique case (r_state)
        StIdle: begin
          if (|w_avail) begin
            r_ring_slot <= w_sel;
            r_state     <= StRing;
            r_aud_en    <= 1'b1;
            r_sec_cnt   <= '0;
          end
        end
        StRing: begin
          if (w_dismiss) begin
            r_state  <= StIdle;
            r_aud_en <= 1'b0;
          end else if (snooze) begin
            r_state   <= StSnooze;
            r_aud_en  <= 1'b0;
            r_min_cnt <= '0;
          end else if (w_tick) begin
            r_sec_cnt <= r_sec_cnt + 1'b1;
          end
        end
        StSnooze: begin
          if (w_dismiss) begin
            r_state  <= StIdle;
            r_aud_en <= 1'b0;
          end else if (w_snz_done) begin
            r_state   <= StRing;
            r_aud_en  <= 1'b1;
            r_sec_cnt <= '0;
          end else if (w_min_evt) begin
            r_min_cnt <= r_min_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_aud_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed table-driven bench for alarm_scheduler (TICK_DIV=10, RING_SEC=3, SNOOZE_MIN=2).
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic [15:0] now_t;
  logic       cfg_we;
  logic [1:0] cfg_slot;
  logic       cfg_en;
  logic [15:0] cfg_t;
  logic       off_bud;
  logic       snooze;
  logic       aud_en;
  logic [1:0] ring_slot;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .NSLOT     (4),
    .TICK_DIV  (10),
    .RING_SEC  (3),
    .SNOOZE_MIN(2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .hourdec_now(now_t[15:12]),
    .hourone_now(now_t[11:8]),
    .mindec_now (now_t[7:4]),
    .minone_now (now_t[3:0]),
    .cfg_we     (cfg_we),
    .cfg_slot   (cfg_slot),
    .cfg_en     (cfg_en),
    .cfg_hourdec(cfg_t[15:12]),
    .cfg_hourone(cfg_t[11:8]),
    .cfg_mindec (cfg_t[7:4]),
    .cfg_minone (cfg_t[3:0]),
    .off_bud    (off_bud),
    .snooze     (snooze),
    .aud_en     (aud_en),
    .ring_slot  (ring_slot),
    .pending    (pending)
  );

  typedef struct {
    logic [15:0] now;
    logic        we;
    logic [1:0]  slot;
    logic        en;
    logic [15:0] ctime;
    logic        off;
    logic        snz;
    int          wait_n;
    logic        exp_aud;
    logic [1:0]  exp_slot;
    logic [3:0]  exp_pend;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [15:0] now, logic we, logic [1:0] slot, logic en,
                              logic [15:0] ctime, logic off, logic snz, int wait_n,
                              logic exp_aud, logic [1:0] exp_slot, logic [3:0] exp_pend);
    vec_t v;
    v.now = now; v.we = we; v.slot = slot; v.en = en; v.ctime = ctime;
    v.off = off; v.snz = snz; v.wait_n = wait_n;
    v.exp_aud = exp_aud; v.exp_slot = exp_slot; v.exp_pend = exp_pend;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic e_aud, logic [1:0] e_slot, logic [3:0] e_pend);
    checks++;
    if (aud_en !== e_aud) begin
      errors++;
      $display("FAIL %s aud_en: got %b want %b", name, aud_en, e_aud);
    end
    checks++;
    if (ring_slot !== e_slot) begin
      errors++;
      $display("FAIL %s ring_slot: got %0d want %0d", name, ring_slot, e_slot);
    end
    checks++;
    if (pending !== e_pend) begin
      errors++;
      $display("FAIL %s pending: got %b want %b", name, pending, e_pend);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    now_t    = v.now;
    cfg_we   = v.we;
    cfg_slot = v.slot;
    cfg_en   = v.en;
    cfg_t    = v.ctime;
    off_bud  = v.off;
    snooze   = v.snz;
    tick();
    cfg_we  = 1'b0;
    off_bud = 1'b0;
    snooze  = 1'b0;
    repeat (v.wait_n) tick();
    check($sformatf("vec%0d", idx), v.exp_aud, v.exp_slot, v.exp_pend);
  endtask

  initial begin
    //                now       we   sl    en   ctime     off  snz wait aud  slot  pend
    vq.push_back(mk(16'h0729, 1'b1, 2'd0, 1'b1, 16'h0730, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0000));
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0001));
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd0, 4'b0001));
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 2'd0, 4'b0000));
    // off/snooze in IDLE do nothing
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 1'b0, 2'd0, 4'b0000));
    vq.push_back(mk(16'h0731, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0000));
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0001));
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd0, 4'b0001));
    // snooze, then two minute changes bring the ring back
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 2'd0, 4'b0001));
    vq.push_back(mk(16'h0731, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0001));
    vq.push_back(mk(16'h0732, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd0, 4'b0001));
    vq.push_back(mk(16'h0732, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 2'd0, 4'b0000));
    // slots 1 and 2 at 08:00
    vq.push_back(mk(16'h0732, 1'b1, 2'd1, 1'b1, 16'h0800, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0000));
    vq.push_back(mk(16'h0732, 1'b1, 2'd2, 1'b1, 16'h0800, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0000));
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd0, 4'b0110));
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd1, 4'b0110));
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 2'd1, 4'b0100));
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd2, 4'b0100));
    // auto-dismiss: still ringing after 29 cycles, silent after 30
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 28, 1'b1, 2'd2, 4'b0100));
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd2, 4'b0000));
    // slot3 rings; a new match for slots 1,2 does not preempt it
    vq.push_back(mk(16'h0800, 1'b1, 2'd3, 1'b1, 16'h0801, 1'b0, 1'b0, 0, 1'b0, 2'd2, 4'b0000));
    vq.push_back(mk(16'h0801, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd2, 4'b1000));
    vq.push_back(mk(16'h0801, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd3, 4'b1000));
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd3, 4'b1110));
    // off_bud and snooze together dismiss
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 2'd3, 4'b0110));
    vq.push_back(mk(16'h0800, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd1, 4'b0110));
    // disabling the ringing slot acts as off_bud
    vq.push_back(mk(16'h0800, 1'b1, 2'd1, 1'b0, 16'h0800, 1'b0, 1'b0, 0, 1'b0, 2'd1, 4'b0100));
    // disabling a pending slot while IDLE clears it before it can ring
    vq.push_back(mk(16'h0800, 1'b1, 2'd2, 1'b0, 16'h0800, 1'b0, 1'b0, 0, 1'b0, 2'd1, 4'b0000));
    vq.push_back(mk(16'h0731, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 1'b0, 2'd1, 4'b0000));
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 2'd1, 4'b0001));
    vq.push_back(mk(16'h0730, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 2'd0, 4'b0001));

    rstn     = 1'b0;
    now_t    = 16'h0729;
    cfg_we   = 1'b0;
    cfg_slot = 2'd0;
    cfg_en   = 1'b0;
    cfg_t    = 16'h0000;
    off_bud  = 1'b0;
    snooze   = 1'b0;
    tick();
    tick();
    check("reset", 1'b0, 2'd0, 4'b0000);
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Asynchronous reset mid-RING silences the sounder without a clock edge.
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", 1'b0, 2'd0, 4'b0000);
    tick();
    rstn = 1'b1;
    tick();
    // Slot0 was disabled by reset, so returning to 07:30 must not trigger it.
    now_t = 16'h0731;
    tick();
    now_t = 16'h0730;
    tick();
    tick();
    check("post_reset_disabled", 1'b0, 2'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
